// File: rtl/gx4000_asic_lock.sv
// -----------------------------------------------------------------------------
// gx4000_asic_lock
//
// Plus-ASIC lock/unlock sequencer with RMR2 page control. Snoops CPU I/O
// writes to the CRTC select port, recognises a sync byte, a zero, a fixed
// pattern and finally a key byte that unlocks (or locks) the ASIC. While
// unlocked, RMR2 writes on the gate-array port map the ASIC register page at
// &4000-&7FFF.
//
// Parameters
//   PAT_LEN   number of pattern bytes between sync and key (1..31)
//   PATTERN   packed 8*PAT_LEN vector, byte 0 in the MSBs
//   KEY       key byte that unlocks; any other key byte locks
//   SEQ_PORT  io_addr[15:8] of the sequence port
//   RMR_PORT  io_addr[15:8] of the gate-array / RMR2 port
//   STICKY    1 = once unlocked, a wrong key byte never relocks
//   TIMEOUT   0 = disabled, else max cycles between sequence writes
//
// Ports
//   clk_sys        in   system clock
//   reset          in   synchronous, active-low reset
//   plus_mode      in   Plus features enabled; 0 holds idle and locked
//   io_addr[7:0]   in   CPU I/O address bits [15:8]
//   io_data[7:0]   in   CPU write data
//   io_wr          in   CPU I/O write strobe (level, may be held)
//   unlocked       out  ASIC unlocked
//   asic_page_en   out  ASIC register page mapped at &4000-&7FFF
//   unlock_pulse   out  one-cycle pulse on a successful key
//   lock_pulse     out  one-cycle pulse when a key byte relocks the ASIC
//   seq_pos[4:0]   out  current pattern index (0 outside MATCH)
//   attempt_count  out  key evaluations since reset, saturating at 255
// -----------------------------------------------------------------------------
module gx4000_asic_lock #(
    parameter int                   PAT_LEN  = 13,
    parameter logic [8*PAT_LEN-1:0] PATTERN  = 104'hFF77B351A8D462399C462B158A,
    parameter logic [7:0]           KEY      = 8'hCD,
    parameter logic [7:0]           SEQ_PORT = 8'hBC,
    parameter logic [7:0]           RMR_PORT = 8'h7F,
    parameter bit                   STICKY   = 1'b0,
    parameter int                   TIMEOUT  = 0
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       plus_mode,
    input  logic [7:0] io_addr,
    input  logic [7:0] io_data,
    input  logic       io_wr,
    output logic       unlocked,
    output logic       asic_page_en,
    output logic       unlock_pulse,
    output logic       lock_pulse,
    output logic [4:0] seq_pos,
    output logic [7:0] attempt_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_MATCH = 2'd2;
    localparam logic [1:0] ST_KEY   = 2'd3;

    // A zero-width counter is not legal, so keep one bit when disabled.
    localparam int             TW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0]  TO_LAST  = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam logic [4:0]     LAST_POS = 5'(PAT_LEN - 1);

    logic [1:0]    state_reg, state_next;
    logic [4:0]    seq_pos_reg, seq_pos_next;
    logic          unlocked_reg, unlocked_next;
    logic          page_en_reg, page_en_next;
    logic          unlock_pulse_reg, unlock_pulse_next;
    logic          lock_pulse_reg, lock_pulse_next;
    logic [7:0]    attempt_reg, attempt_next;
    logic [TW-1:0] to_cnt_reg, to_cnt_next;
    logic          wr_prev_reg;

    logic          wr_edge;
    logic          seq_wr;
    logic          rmr_wr;
    logic          to_fire;
    logic [7:0]    pat_byte;
    logic [7:0]    pat_bytes [PAT_LEN];

    // Unpack the pattern vector; byte 0 sits in the most significant byte.
    for (genvar gi = 0; gi < PAT_LEN; gi++) begin : g_pat
        assign pat_bytes[gi] = PATTERN[8*(PAT_LEN-1-gi) +: 8];
    end

    always_comb begin
        pat_byte = 8'h00;
        for (int i = 0; i < PAT_LEN; i++) begin
            if (seq_pos_reg == 5'(i)) begin
                pat_byte = pat_bytes[i];
            end
        end
    end

    // A held strobe counts once: only the low-to-high transition qualifies.
    assign wr_edge = io_wr & ~wr_prev_reg;
    assign seq_wr  = wr_edge & plus_mode & (io_addr == SEQ_PORT);
    assign rmr_wr  = wr_edge & plus_mode & (io_addr == RMR_PORT);
    // Fires on the edge where the counter would reach TIMEOUT.
    assign to_fire = (TIMEOUT > 0) && (state_reg != ST_IDLE) && (to_cnt_reg == TO_LAST);

    always_comb begin
        state_next        = state_reg;
        seq_pos_next      = seq_pos_reg;
        unlocked_next     = unlocked_reg;
        page_en_next      = page_en_reg;
        unlock_pulse_next = 1'b0;
        lock_pulse_next   = 1'b0;
        attempt_next      = attempt_reg;
        to_cnt_next       = to_cnt_reg;

        if (!plus_mode) begin
            state_next    = ST_IDLE;
            seq_pos_next  = 5'd0;
            unlocked_next = 1'b0;
            page_en_next  = 1'b0;
            to_cnt_next   = '0;
        end else begin
            if (seq_wr) begin
                // A sequence write always beats a timeout on the same edge.
                to_cnt_next = '0;
                case (state_reg)
                    ST_IDLE: begin
                        if (io_data != 8'h00) begin
                            state_next = ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (io_data == 8'h00) begin
                            state_next   = ST_MATCH;
                            seq_pos_next = 5'd0;
                        end
                    end
                    ST_MATCH: begin
                        if (io_data == pat_byte) begin
                            if (seq_pos_reg == LAST_POS) begin
                                state_next   = ST_KEY;
                                seq_pos_next = 5'd0;
                            end else begin
                                seq_pos_next = seq_pos_reg + 5'd1;
                            end
                        end else if (io_data == 8'h00) begin
                            // A zero is itself a valid sync; restart the pattern.
                            seq_pos_next = 5'd0;
                        end else begin
                            state_next   = ST_ARMED;
                            seq_pos_next = 5'd0;
                        end
                    end
                    default: begin
                        if (attempt_reg != 8'hFF) begin
                            attempt_next = attempt_reg + 8'd1;
                        end
                        if (io_data == KEY) begin
                            unlocked_next     = 1'b1;
                            unlock_pulse_next = 1'b1;
                        end else if (!(STICKY && unlocked_reg)) begin
                            unlocked_next   = 1'b0;
                            page_en_next    = 1'b0;
                            lock_pulse_next = unlocked_reg;
                        end
                        state_next = (io_data != 8'h00) ? ST_ARMED : ST_IDLE;
                    end
                endcase
            end else if ((TIMEOUT > 0) && (state_reg != ST_IDLE)) begin
                if (to_fire) begin
                    state_next   = ST_IDLE;
                    seq_pos_next = 5'd0;
                    to_cnt_next  = '0;
                end else begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                end
            end

            // RMR2 form is 101x_x___; bits [4:3]=11 select the register page.
            if (rmr_wr && unlocked_reg && (io_data[7:5] == 3'b101)) begin
                page_en_next = (io_data[4:3] == 2'b11);
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            state_reg        <= ST_IDLE;
            seq_pos_reg      <= 5'd0;
            unlocked_reg     <= 1'b0;
            page_en_reg      <= 1'b0;
            unlock_pulse_reg <= 1'b0;
            lock_pulse_reg   <= 1'b0;
            attempt_reg      <= 8'd0;
            to_cnt_reg       <= '0;
            wr_prev_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            seq_pos_reg      <= seq_pos_next;
            unlocked_reg     <= unlocked_next;
            page_en_reg      <= page_en_next;
            unlock_pulse_reg <= unlock_pulse_next;
            lock_pulse_reg   <= lock_pulse_next;
            attempt_reg      <= attempt_next;
            to_cnt_reg       <= to_cnt_next;
            wr_prev_reg      <= io_wr;
        end
    end

    assign unlocked      = unlocked_reg;
    assign asic_page_en  = page_en_reg;
    assign unlock_pulse  = unlock_pulse_reg;
    assign lock_pulse    = lock_pulse_reg;
    assign seq_pos       = seq_pos_reg;
    assign attempt_count = attempt_reg;

endmodule
